apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB memory-mapped slave with configurable data width, memory depth, byte-lane write strobes, programmable wait states and address-decoded error response. Sits behind the APB bridge as a register/scratch-memory target. It is the generalised successor of the fixed 8-bit, 256-entry APB slave, adding Pstrb, wait states and a cleanly registered response path.

## Interface
- ADDR_WIDTH, 8: Paddr width; word address, one memory entry per address.
- DATA_WIDTH, 32: Pwdata/Prdata width; multiple of 8.
- DEPTH, 256: memory entries, ≤ 2^ADDR_WIDTH.
- WAIT_STATES, 2: access-phase cycles with Pready low before completion, 0..15.
- ERR_ADDR, 8'hCA: address that always responds with Pslverr.

Ports:
- Pclk  in  1  clock; all state changes on rising edge.
- Preset  in  1  asynchronous, active-high reset.
- Psel  in  1  slave select.
- Penable  in  1  access-phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  ADDR_WIDTH  word address.
- Pwdata  in  DATA_WIDTH  write data.
- Pstrb  in  DATA_WIDTH/8  write byte enables; bit i covers Pwdata[8i+7:8i].
- Prdata  out  DATA_WIDTH  read data, valid only while Pready=1.
- Pready  out  1  transfer completes on an edge where Pready=1 and Penable=1.
- Pslverr  out  1  error response, valid only while Pready=1.

## Operation
- States: IDLE, ACCESS. Wait counter wcnt is 4 bits.
- Reset (async, immediate): state=IDLE, wcnt=0, Pready=0, Pslverr=0, Prdata=0. Memory is not cleared.
- IDLE: an edge with Psel=1, Penable=0 is a setup phase. At that edge the block latches Paddr and Pwrite, computes err = (Paddr==ERR_ADDR) || (Paddr>=DEPTH), loads wcnt=WAIT_STATES, and moves to ACCESS.
  - If WAIT_STATES==0, the same edge sets Pready=1 and drives the response (see below).
- ACCESS while Pready=0: each edge with Psel=1, Penable=1 decrements wcnt. The edge where wcnt==1 sets Pready=1 and drives the response.
- Response drive:
  - Pslverr=err.
  - Read with !err: Prdata = mem[latched addr].
  - Read with err: Prdata=0.
  - Write: Prdata=0.
- Completion edge (ACCESS, Pready=1, Psel=1, Penable=1):
  - Write with !err: for each i with Pstrb[i]=1, mem[addr] byte i ← Pwdata byte i. Other bytes are unchanged. Pstrb=0 is legal and is a no-op.
  - Write with err: memory is unchanged.
  - Next cycle: Pready=0, Pslverr=0, Prdata=0, state=IDLE.
- Abort: an edge in ACCESS with Psel=0 or Penable=0 before completion returns to IDLE. No memory write occurs and all outputs return to 0.
- Pstrb is ignored on reads.
- Paddr and Pwrite changes during ACCESS are ignored; the latched values are used. Pwdata and Pstrb are sampled at the completion edge.

## Timing
- Setup cycle counts as cycle 0. Pready is high in access cycle WAIT_STATES+1, so a transfer takes WAIT_STATES+2 cycles.
- Zero-wait transfer takes 2 cycles. Back-to-back transfers (setup immediately after completion) sustain one transfer per WAIT_STATES+2 cycles with no dead cycle.
- Read data and Pslverr are registered. They change only on the edge that raises Pready and clear on the edge after completion.
- Pready is high for exactly one cycle per completed transfer.
- A write is visible to a read whose setup edge comes after the write's completion edge. This includes the immediately following transfer.
- Preset asserted mid-transfer: outputs go to 0 without waiting for a clock edge, and no write occurs. After deassertion the first Psel=1, Penable=0 edge starts a fresh transfer.

## Test plan
- Config: DATA_WIDTH=32, WAIT_STATES=2. Write 0xDEADBEEF to 0x10 with Pstrb=4'hF, then read 0x10.
  - Pready high in access cycle 3 for both transfers. Prdata=0xDEADBEEF, Pslverr=0. Each transfer takes 4 cycles.
- Byte strobes: write 0x11223344 to 0x20 with Pstrb=4'hF, then write 0xAABBCCDD with Pstrb=4'b0101, then read 0x20.
  - Read returns 0x11BB33DD.
- Error address: write 0x55 to 0xCA, then read 0xCA.
  - Both complete with Pslverr=1. Read Prdata=0. A read of 0xCA with DEPTH=256 still returns 0, confirming no write.
  - With DEPTH=128, a read of 0x90 returns Pslverr=1.
- Zero-wait config (WAIT_STATES=0): back-to-back writes to 0x01, 0x02, 0x03, then reads of the same addresses.
  - Pready high in every first access cycle. Six transfers take 12 cycles. Correct data is returned.
- Abort: write setup to 0x30, then drop Penable after 1 access cycle (WAIT_STATES=2).
  - Pready never rises. Returns to IDLE. A subsequent read of 0x30 returns the old value.
- Reset mid-read at access cycle 2: Pready, Pslverr and Prdata are 0 immediately.
  - The next full read of 0x10 returns the previously written 0xDEADBEEF.

Source files
------------

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB scratch-memory slave with byte strobes, wait states and error decode
// Registered response path; memory contents survive reset.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] ERR_ADDR = 8'hCA
) (
  input  logic                    Pclk,
  input  logic                    Preset,
  input  logic                    Psel,
  input  logic                    Penable,
  input  logic                    Pwrite,
  input  logic [ADDR_WIDTH-1:0]   Paddr,
  input  logic [DATA_WIDTH-1:0]   Pwdata,
  input  logic [DATA_WIDTH/8-1:0] Pstrb,
  output logic [DATA_WIDTH-1:0]   Prdata,
  output logic                    Pready,
  output logic                    Pslverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state, state_d;
  logic [3:0]              wcnt, wcnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic                    pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_d;
  logic                    mem_we;
  logic                    setup_err;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign setup_err = (Paddr == ERR_ADDR) ||
                     ({{(32-ADDR_WIDTH){1'b0}}, Paddr} >= 32'(DEPTH));

  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    addr_d    = addr_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = Pready;
    pslverr_d = Pslverr;
    prdata_d  = Prdata;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (Psel && !Penable) begin
          state_d = ACCESS;
          addr_d  = Paddr;
          write_d = Pwrite;
          err_d   = setup_err;
          wcnt_d  = WS;
          // Zero-wait: the response is ready in the very first access cycle
          if (WS == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (Pwrite || setup_err) ? '0 : mem[Paddr[IDX_W-1:0]];
          end
        end
      end
      ACCESS: begin
        if (!(Psel && Penable)) begin
          state_d   = IDLE;
          wcnt_d    = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (Pready) begin
          mem_we    = write_q && !err_q;
          state_d   = IDLE;
          wcnt_d    = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else begin
          wcnt_d = wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (write_q || err_q) ? '0 : mem[addr_q[IDX_W-1:0]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end else begin
      state   <= state_d;
      wcnt    <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
      Pready  <= pready_d;
      Pslverr <= pslverr_d;
      Prdata  <= prdata_d;
    end
  end

  always_ff @(posedge Pclk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (Pstrb[i]) mem[addr_q[IDX_W-1:0]][8*i +: 8] <= Pwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - self-checking bench for apb_mem_slave
// Three instances: 2 wait states, zero wait states, and DEPTH=128 with 1 wait state.
module tb_apb_mem_slave;

  logic        Pclk = 1'b0;
  logic        Preset = 1'b1;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready, pslverr;

  always #5 Pclk = ~Pclk;

  apb_mem_slave #(.WAIT_STATES(2)) u_ws2 (
    .Pclk(Pclk), .Preset(Preset), .Psel(psel[0]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
    .Pclk(Pclk), .Preset(Preset), .Psel(psel[1]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  apb_mem_slave #(.DEPTH(128), .WAIT_STATES(1)) u_d128 (
    .Pclk(Pclk), .Preset(Preset), .Psel(psel[2]), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb),
    .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Pclk) cyc <= cyc + 1;

  // Reference model: word array plus per-byte "has been written" flags
  logic [31:0] mdl [3][256];
  logic [3:0]  vld [3][256];

  typedef struct {
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  sb;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic int ws_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 1;
  endfunction

  function automatic int dep_of(int d);
    return (d == 2) ? 128 : 256;
  endfunction

  function automatic bit m_err(int d, logic [7:0] a);
    return (a == 8'hCA) || (int'(a) >= dep_of(d));
  endfunction

  function automatic logic [31:0] byte_mask(logic [3:0] v);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{v[b]}};
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, output logic [31:0] rd, output logic se, output int nc);
    bit done = 0;
    rd = '0; se = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = sb; penable = 1'b0;
    psel = 3'b000; psel[d] = 1'b1;
    @(negedge Pclk);
    check("setup_idle_outputs", {pready[d], pslverr[d]} | prdata[d], 32'h0);
    @(posedge Pclk); #1;
    nc = 1;
    penable = 1'b1;
    while (!done && nc < 40) begin
      @(negedge Pclk);
      if (pready[d]) begin
        rd = prdata[d];
        se = pslverr[d];
        done = 1;
      end else begin
        check("wait_outputs_zero", {31'h0, pslverr[d]} | prdata[d], 32'h0);
      end
      @(posedge Pclk); #1;
      nc++;
    end
    if (!done) check("xfer_timeout", 32'h1, 32'h0);
    psel = 3'b000; penable = 1'b0;
  endtask

  task automatic do_op(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, output logic [31:0] rd, output logic se, output int nc);
    xfer(d, wr, a, wd, sb, rd, se, nc);
    if (wr && !m_err(d, a)) begin
      for (int b = 0; b < 4; b++) begin
        if (sb[b]) begin
          mdl[d][a][8*b +: 8] = wd[8*b +: 8];
          vld[d][a][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic reset_mid(input bit wr, input logic [31:0] wd, input int k,
                           input bit exp_rdy, input logic [31:0] exp_pre_rd);
    paddr = 8'h10; pwrite = wr; pwdata = wd; pstrb = 4'hF;
    psel = 3'b001; penable = 1'b0;
    @(posedge Pclk); #1;
    penable = 1'b1;
    repeat (k - 1) begin @(posedge Pclk); #1; end
    check($sformatf("rst_pre_ready_k%0d", k), 32'(pready[0]), 32'(exp_rdy));
    if (exp_rdy) check($sformatf("rst_pre_rdata_k%0d", k), prdata[0], exp_pre_rd);
    #2 Preset = 1'b1;
    #1;
    check($sformatf("rst_async_ready_k%0d", k), 32'(pready[0]), 32'h0);
    check($sformatf("rst_async_slverr_k%0d", k), 32'(pslverr[0]), 32'h0);
    check($sformatf("rst_async_rdata_k%0d", k), prdata[0], 32'h0);
    psel = 3'b000; penable = 1'b0;
    @(posedge Pclk); #1;
    Preset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd, m;
    logic        se;
    int          nc, t0;
    bit          saw;

    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++) begin
        mdl[d][a] = '0;
        vld[d][a] = '0;
      end

    tbl.push_back('{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 8'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0});
    tbl.push_back('{0, 1'b1, 8'hCA, 32'h00000055, 4'hF, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 8'hCA, 32'h0,        4'h0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b1, 8'hFF, 32'h600DF00D, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b1, 8'hFF, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 8'hFF, 32'h0,        4'h0, 32'h600DF00D, 1'b0});
    tbl.push_back('{2, 1'b0, 8'h90, 32'h0,        4'h0, 32'h0,        1'b1});
    tbl.push_back('{2, 1'b1, 8'h7F, 32'h01020304, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{2, 1'b0, 8'h7F, 32'h0,        4'h0, 32'h01020304, 1'b0});
    tbl.push_back('{2, 1'b1, 8'h80, 32'h99999999, 4'hF, 32'h0,        1'b1});
    tbl.push_back('{2, 1'b0, 8'h80, 32'h0,        4'h0, 32'h0,        1'b1});

    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge Pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready_%0d", d), 32'(pready[d]), 32'h0);
      check($sformatf("reset_slverr_%0d", d), 32'(pslverr[d]), 32'h0);
      check($sformatf("reset_rdata_%0d", d), prdata[d], 32'h0);
    end
    Preset = 1'b0;

    foreach (tbl[i]) begin
      do_op(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sb, rd, se, nc);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
      check($sformatf("tbl%0d_slverr", i), 32'(se), 32'(tbl[i].eerr));
      check($sformatf("tbl%0d_cycles", i), nc, ws_of(tbl[i].d) + 2);
    end

    // Abort: drop Penable after one access cycle of a write to 0x30
    saw = 0;
    paddr = 8'h30; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
    psel = 3'b001; penable = 1'b0;
    @(posedge Pclk); #1;
    penable = 1'b1;
    @(negedge Pclk); saw |= pready[0];
    @(posedge Pclk); #1;
    penable = 1'b0;
    @(negedge Pclk); saw |= pready[0];
    @(posedge Pclk); #1;
    psel = 3'b000;
    @(negedge Pclk); saw |= pready[0];
    check("abort_no_ready", 32'(saw), 32'h0);
    check("abort_outputs_zero", {31'h0, pslverr[0]} | prdata[0], 32'h0);
    @(posedge Pclk); #1;
    do_op(0, 1'b0, 8'h30, 32'h0, 4'h0, rd, se, nc);
    check("abort_old_value", rd, 32'hCAFEF00D);
    check("abort_read_cycles", nc, 4);

    // Zero-wait back-to-back: six transfers, no dead cycle
    t0 = cyc;
    for (int i = 1; i <= 3; i++) begin
      do_op(1, 1'b1, 8'(i), 32'hB0B0_0000 + 32'(i), 4'hF, rd, se, nc);
      check($sformatf("b2b_wr%0d_cycles", i), nc, 2);
    end
    for (int i = 1; i <= 3; i++) begin
      do_op(1, 1'b0, 8'(i), 32'h0, 4'h0, rd, se, nc);
      check($sformatf("b2b_rd%0d_data", i), rd, 32'hB0B0_0000 + 32'(i));
      check($sformatf("b2b_rd%0d_cycles", i), nc, 2);
    end
    check("b2b_total_cycles", cyc - t0, 12);

    // Reset mid-transfer: read in access cycle 2 and 3, write in access cycle 3
    reset_mid(1'b0, 32'h0, 2, 1'b0, 32'h0);
    reset_mid(1'b0, 32'h0, 3, 1'b1, 32'hDEADBEEF);
    reset_mid(1'b1, 32'h12345678, 3, 1'b1, 32'h0);
    do_op(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, se, nc);
    check("post_reset_rdata", rd, 32'hDEADBEEF);
    check("post_reset_slverr", 32'(se), 32'h0);
    check("post_reset_cycles", nc, 4);

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      int          d, r;
      bit          wr, e;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [3:0]  sb;
      d  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      a  = (r < 6) ? 8'($urandom_range(0, 15)) :
           (r == 6) ? 8'hCA :
           (r == 7) ? 8'h80 : 8'($urandom);
      wd = $urandom;
      sb = 4'($urandom);
      e  = m_err(d, a);
      if (wr || e) begin
        erd = 32'h0;
        m   = 32'hFFFFFFFF;
      end else begin
        erd = mdl[d][a];
        m   = byte_mask(vld[d][a]);
      end
      do_op(d, wr, a, wd, sb, rd, se, nc);
      check($sformatf("rand%0d_rdata", n), rd & m, erd & m);
      check($sformatf("rand%0d_slverr", n), 32'(se), 32'(e));
      check($sformatf("rand%0d_cycles", n), nc, ws_of(d) + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
